// File: rtl/riscv_lsu_wb.sv
// Load/store unit for the multi-cycle RV32 core: one request per handshake onto a Wishbone B4
// classic data master, with lane steering, load extension, misalignment, bus-error and watchdog reporting.
module riscv_lsu_wb #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MISALIGN_TRAP  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [1:0]            rsp_err_code,
    output logic [ADDR_WIDTH-1:0] dwb_adr_o,
    output logic [31:0]           dwb_dat_o,
    input  logic [31:0]           dwb_dat_i,
    output logic                  dwb_we_o,
    output logic [3:0]            dwb_sel_o,
    output logic                  dwb_cyc_o,
    output logic                  dwb_stb_o,
    input  logic                  dwb_ack_i,
    input  logic                  dwb_err_i
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUS = 2'd1, ST_RESP = 2'd2} state_t;

    localparam int               CNT_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [1:0]       CODE_NONE    = 2'd0;
    localparam logic [1:0]       CODE_ALIGN   = 2'd1;
    localparam logic [1:0]       CODE_BUS     = 2'd2;
    localparam logic [1:0]       CODE_TIMEOUT = 2'd3;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       size_r, off_r;
    logic             uns_r;
    logic             bad_s, timeout_s;
    logic [1:0]       code_s;
    logic [31:0]      rdata_s;

    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_sel = 4'b0001 << off;
            2'd1:    lane_sel = 4'b0011 << {off[1], 1'b0};
            2'd2:    lane_sel = 4'b1111;
            default: lane_sel = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'd0:    lane_data = {4{wdata[7:0]}};
            2'd1:    lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase
    endfunction

    // A half access ignores a[0] when alignment is forced, so the shift uses a[1] only.
    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                                input logic [1:0] off, input logic [31:0] dat);
        logic [31:0] sh;
        sh = 32'd0;
        case (size)
            2'd0: begin
                sh = dat >> {off, 3'b000};
                load_extend = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'd1: begin
                sh = dat >> {off[1], 4'b0000};
                load_extend = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: load_extend = dat;
        endcase
    endfunction

    // Requests answered without a bus cycle: illegal size or trapped misalignment
    always_comb begin
        bad_s = 1'b0;
        case (req_size)
            2'd1:    bad_s = (MISALIGN_TRAP != 0) && req_addr[0];
            2'd2:    bad_s = (MISALIGN_TRAP != 0) && (req_addr[1:0] != 2'b00);
            2'd3:    bad_s = 1'b1;
            default: bad_s = 1'b0;
        endcase
    end

    // Watchdog expiry on the last permitted BUS cycle
    always_comb begin
        timeout_s = 1'b0;
        if (TIMEOUT_CYCLES != 0) begin
            timeout_s = (cnt_r == CNT_LAST);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next state plus the response that will be registered on entry to RESP
    always_comb begin
        state_s = state_r;
        code_s  = CODE_NONE;
        rdata_s = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_s = bad_s ? ST_RESP : ST_BUS;
                    code_s  = bad_s ? CODE_ALIGN : CODE_NONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (dwb_err_i) begin
                    state_s = ST_RESP;
                    code_s  = CODE_BUS;
                end else if (dwb_ack_i) begin
                    state_s = ST_RESP;
                    rdata_s = dwb_we_o ? 32'd0 : load_extend(size_r, uns_r, off_r, dwb_dat_i);
                end else if (timeout_s) begin
                    state_s = ST_RESP;
                    code_s  = CODE_TIMEOUT;
                end else begin
                    state_s = ST_BUS;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, handshake/response registers, request latch and watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_err_code <= CODE_NONE;
            rsp_rdata    <= 32'd0;
            cnt_r        <= {CNT_W{1'b0}};
            size_r       <= 2'd0;
            off_r        <= 2'd0;
            uns_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            req_ready    <= (state_s == ST_IDLE);
            rsp_valid    <= (state_s == ST_RESP);
            rsp_err      <= (state_s == ST_RESP) && (code_s != CODE_NONE);
            rsp_err_code <= code_s;
            rsp_rdata    <= rdata_s;
            if (state_r == ST_IDLE) begin
                cnt_r <= {CNT_W{1'b0}};
                if (req_valid) begin
                    size_r <= req_size;
                    off_r  <= req_addr[1:0];
                    uns_r  <= req_unsigned;
                end
            end else if ((state_r == ST_BUS) && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
        end
    end

    // Wishbone master outputs: loaded on acceptance, held through BUS, cleared on exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwb_cyc_o <= 1'b0;
            dwb_stb_o <= 1'b0;
            dwb_we_o  <= 1'b0;
            dwb_sel_o <= 4'b0000;
            dwb_adr_o <= {ADDR_WIDTH{1'b0}};
            dwb_dat_o <= 32'd0;
        end else if ((state_r == ST_IDLE) && req_valid && !bad_s) begin
            dwb_cyc_o <= 1'b1;
            dwb_stb_o <= 1'b1;
            dwb_we_o  <= req_we;
            dwb_sel_o <= lane_sel(req_size, req_addr[1:0]);
            dwb_adr_o <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            dwb_dat_o <= lane_data(req_size, req_wdata);
        end else if ((state_r == ST_BUS) && (state_s != ST_BUS)) begin
            dwb_cyc_o <= 1'b0;
            dwb_stb_o <= 1'b0;
            dwb_we_o  <= 1'b0;
            dwb_sel_o <= 4'b0000;
            dwb_adr_o <= {ADDR_WIDTH{1'b0}};
            dwb_dat_o <= 32'd0;
        end
    end

endmodule

// File: tb/tb_riscv_lsu_wb.sv
// Self-checking bench for riscv_lsu_wb: directed corner cases plus random traffic scored
// against a byte-level reference model; a second instance covers no-watchdog / forced alignment.
module tb_riscv_lsu_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_valid1, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, dwb_dat_i;
    logic        dwb_ack_i, dwb_err_i;

    logic        req_ready, rsp_valid, rsp_err, dwb_we_o, dwb_cyc_o, dwb_stb_o;
    logic [1:0]  rsp_err_code;
    logic [31:0] rsp_rdata, dwb_adr_o, dwb_dat_o;
    logic [3:0]  dwb_sel_o;

    logic        req_ready1, rsp_valid1, rsp_err1, dwb_we_o1, dwb_cyc_o1, dwb_stb_o1;
    logic [1:0]  rsp_err_code1;
    logic [31:0] rsp_rdata1, dwb_adr_o1, dwb_dat_o1;
    logic [3:0]  dwb_sel_o1;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the last transaction run by run_txn
    bit          t_done, t_we, t_stable, t_rerr, t_extra;
    int          t_lat, t_bus;
    logic [3:0]  t_sel;
    logic [31:0] t_dat, t_adr, t_rdata;
    logic [1:0]  t_code;

    always #5 clk = ~clk;

    riscv_lsu_wb #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16), .MISALIGN_TRAP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_err_code(rsp_err_code),
        .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_dat_i(dwb_dat_i), .dwb_we_o(dwb_we_o),
        .dwb_sel_o(dwb_sel_o), .dwb_cyc_o(dwb_cyc_o), .dwb_stb_o(dwb_stb_o), .dwb_ack_i(dwb_ack_i),
        .dwb_err_i(dwb_err_i));

    riscv_lsu_wb #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(0), .MISALIGN_TRAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .rsp_err_code(rsp_err_code1),
        .dwb_adr_o(dwb_adr_o1), .dwb_dat_o(dwb_dat_o1), .dwb_dat_i(dwb_dat_i), .dwb_we_o(dwb_we_o1),
        .dwb_sel_o(dwb_sel_o1), .dwb_cyc_o(dwb_cyc_o1), .dwb_stb_o(dwb_stb_o1), .dwb_ack_i(dwb_ack_i),
        .dwb_err_i(dwb_err_i));

    // Reference: what a trapping LSU should do for one request given the slave's answer
    function automatic void model(input bit we, input logic [1:0] size, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                                  input bit err, input bit tmo, output bit bus, output logic [3:0] sel,
                                  output logic [31:0] dat, output logic [31:0] rdata, output logic [1:0] code);
        int     off, nbytes;
        longint v;
        off = int'(addr % 4);
        bus = 1'b1; sel = 4'h0; dat = 32'h0; rdata = 32'h0; code = 2'd0;
        if (size == 2'd3 || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0)) begin
            bus = 1'b0; code = 2'd1;
            return;
        end
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        sel = 4'(((1 << nbytes) - 1) << off);
        if (nbytes == 1) dat = {24'h0, wdata[7:0]} * 32'h01010101;
        else if (nbytes == 2) dat = {16'h0, wdata[15:0]} * 32'h00010001;
        else dat = wdata;
        if (err) code = 2'd2;
        else if (tmo) code = 2'd3;
        else if (!we) begin
            v = longint'(rd >> (8 * off)) % (longint'(1) << (8 * nbytes));
            if (!uns && v >= (longint'(1) << (8 * nbytes - 1))) v = v - (longint'(1) << (8 * nbytes));
            rdata = v[31:0];
        end
    endfunction

    // Issues one request to u_dut and plays the slave; wait_n<0 means the slave never answers
    task automatic run_txn(input bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd, input int wait_n,
                           input bit err_in, input bit both);
        t_done = 0; t_lat = 0; t_bus = 0; t_sel = 4'h0; t_dat = 32'h0; t_adr = 32'h0; t_we = 0;
        t_stable = 1; t_rdata = 32'h0; t_rerr = 0; t_code = 2'd0; t_extra = 0;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        dwb_dat_i = rd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; t_lat = 1;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin
                t_rdata = rsp_rdata; t_rerr = rsp_err; t_code = rsp_err_code; t_done = 1;
                break;
            end
            if (dwb_cyc_o) begin
                if (t_bus == 0) begin
                    t_sel = dwb_sel_o; t_dat = dwb_dat_o; t_adr = dwb_adr_o; t_we = dwb_we_o;
                end
                if (dwb_stb_o !== 1'b1 || dwb_sel_o !== t_sel || dwb_dat_o !== t_dat ||
                    dwb_adr_o !== t_adr || dwb_we_o !== t_we) t_stable = 0;
                if (wait_n >= 0 && t_bus == wait_n) begin
                    dwb_ack_i = !err_in || both;
                    dwb_err_i = err_in;
                end
                t_bus++;
            end
            @(posedge clk); #1;
            dwb_ack_i = 1'b0; dwb_err_i = 1'b0;
            t_lat++;
        end
        if (t_done) begin
            @(posedge clk); #1;
            t_extra = rsp_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; dwb_dat_i = 32'h0;
        dwb_ack_i = 1'b0; dwb_err_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({req_ready, rsp_valid, rsp_err, rsp_err_code, dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_sel_o} !== 12'h800) begin n_fail++; $display("FAIL reset_ctrl_in_reset: got %h expected 800", {req_ready, rsp_valid, rsp_err, rsp_err_code, dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_sel_o}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({req_ready, rsp_valid, rsp_err, rsp_err_code, dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_sel_o} !== 12'h800) begin n_fail++; $display("FAIL reset_ctrl_after: got %h expected 800", {req_ready, rsp_valid, rsp_err, rsp_err_code, dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_sel_o}); end
        n_checks++; if ({rsp_rdata, dwb_adr_o, dwb_dat_o} !== 96'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {rsp_rdata, dwb_adr_o, dwb_dat_o}); end
        n_checks++; if (req_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready1: got %b expected 1", req_ready1); end
    endtask

    task automatic test_directed();
        run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80AA55CC, 1, 1'b0, 1'b0);
        n_checks++; if (t_sel !== 4'b1000) begin n_fail++; $display("FAIL lb_sel: got %b expected 1000", t_sel); end
        n_checks++; if (t_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata: got %h expected ffffff80", t_rdata); end
        n_checks++; if (t_lat !== 3 || t_done !== 1'b1) begin n_fail++; $display("FAIL lb_latency: got %0d expected 3", t_lat); end
        run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80AA55CC, 0, 1'b0, 1'b0);
        n_checks++; if (t_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_rdata: got %h expected 00000080", t_rdata); end
        n_checks++; if (t_lat !== 2) begin n_fail++; $display("FAIL lbu_min_latency: got %0d expected 2", t_lat); end
        run_txn(1'b1, 2'd1, 1'b0, 32'h002, 32'h00001234, 32'hFFFFFFFF, 2, 1'b0, 1'b0);
        n_checks++; if (t_dat !== 32'h12341234) begin n_fail++; $display("FAIL sh_dat: got %h expected 12341234", t_dat); end
        n_checks++; if (t_sel !== 4'b1100 || t_we !== 1'b1 || t_adr !== 32'h0) begin n_fail++; $display("FAIL sh_ctrl: got sel=%b we=%b adr=%h expected 1100/1/0", t_sel, t_we, t_adr); end
        n_checks++; if (t_rdata !== 32'h0 || t_rerr !== 1'b0 || t_lat !== 4) begin n_fail++; $display("FAIL sh_rsp: got rdata=%h err=%b lat=%0d expected 0/0/4", t_rdata, t_rerr, t_lat); end
        n_checks++; if (t_stable !== 1'b1 || t_extra !== 1'b0) begin n_fail++; $display("FAIL sh_stable: got stable=%b extra=%b expected 1/0", t_stable, t_extra); end
    endtask

    task automatic test_misalign();
        run_txn(1'b0, 2'd2, 1'b0, 32'h006, 32'h0, 32'h11223344, 0, 1'b0, 1'b0);
        n_checks++; if (t_bus !== 0 || t_lat !== 1) begin n_fail++; $display("FAIL lw_mis_nobus: got bus=%0d lat=%0d expected 0/1", t_bus, t_lat); end
        n_checks++; if (t_rerr !== 1'b1 || t_code !== 2'd1 || t_rdata !== 32'h0) begin n_fail++; $display("FAIL lw_mis_code: got err=%b code=%0d expected 1/1", t_rerr, t_code); end
        run_txn(1'b1, 2'd3, 1'b0, 32'h010, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        n_checks++; if (t_bus !== 0 || t_code !== 2'd1 || t_done !== 1'b1) begin n_fail++; $display("FAIL size3_code: got bus=%0d code=%0d expected 0/1", t_bus, t_code); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 2'd2, 1'b0, 32'h020, 32'h0, 32'h0, -1, 1'b0, 1'b0);
        n_checks++; if (t_bus !== 16 || t_lat !== 17) begin n_fail++; $display("FAIL timeout_cycles: got bus=%0d lat=%0d expected 16/17", t_bus, t_lat); end
        n_checks++; if (t_code !== 2'd3 || t_rerr !== 1'b1 || t_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_code: got code=%0d err=%b expected 3/1", t_code, t_rerr); end
        n_checks++; if (dwb_cyc_o !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_release: got cyc=%b ready=%b expected 0/1", dwb_cyc_o, req_ready); end
    endtask

    task automatic test_ack_err();
        run_txn(1'b0, 2'd2, 1'b0, 32'h040, 32'h0, 32'hCAFEF00D, 1, 1'b1, 1'b1);
        n_checks++; if (t_code !== 2'd2 || t_rdata !== 32'h0 || t_rerr !== 1'b1) begin n_fail++; $display("FAIL ack_err_both: got code=%0d rdata=%h expected 2/0", t_code, t_rdata); end
        run_txn(1'b1, 2'd0, 1'b0, 32'h041, 32'hAB, 32'h0, 3, 1'b1, 1'b0);
        n_checks++; if (t_code !== 2'd2 || t_lat !== 5) begin n_fail++; $display("FAIL err_only: got code=%0d lat=%0d expected 2/5", t_code, t_lat); end
    endtask

    task automatic test_async_reset();
        req_we = 1'b0; req_size = 2'd2; req_addr = 32'h80; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (dwb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre_cyc: got %b expected 1", dwb_cyc_o); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (dwb_cyc_o !== 1'b0 || dwb_stb_o !== 1'b0) begin n_fail++; $display("FAIL arst_drop: got cyc=%b stb=%b expected 0/0", dwb_cyc_o, dwb_stb_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got ready=%b rsp=%b expected 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int          waits [4] = '{0, 1, 5, 0};
        logic [31:0] rd;
        for (int i = 0; i < 4; i++) begin
            rd = $urandom;
            run_txn(1'b0, 2'd2, 1'b0, 32'h200 + 32'(4 * i), 32'h0, rd, waits[i], 1'b0, 1'b0);
            n_checks++; if (t_rdata !== rd || t_done !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d]_data: got %h expected %h", i, t_rdata, rd); end
            n_checks++; if (t_lat !== waits[i] + 2 || t_extra !== 1'b0) begin n_fail++; $display("FAIL b2b[%0d]_timing: got lat=%0d extra=%b expected %0d/0", i, t_lat, t_extra, waits[i] + 2); end
        end
    endtask

    task automatic test_random();
        bit          we, uns, err, m_bus;
        logic [1:0]  size, m_code;
        logic [31:0] addr, wdata, rd, m_dat, m_rdata;
        logic [3:0]  m_sel;
        int          wt;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom; rd = $urandom;
            wt = $urandom_range(0, 5); err = ($urandom_range(0, 7) == 0);
            model(we, size, uns, addr, wdata, rd, err, 1'b0, m_bus, m_sel, m_dat, m_rdata, m_code);
            run_txn(we, size, uns, addr, wdata, rd, wt, err, 1'b0);
            n_checks++; if (t_rdata !== m_rdata || t_code !== m_code || t_rerr !== (m_code != 2'd0)) begin n_fail++; $display("FAIL rand[%0d]_rsp: got rdata=%h code=%0d err=%b expected %h/%0d", i, t_rdata, t_code, t_rerr, m_rdata, m_code); end
            n_checks++; if ((t_bus != 0) !== m_bus || t_lat !== (m_bus ? wt + 2 : 1) || t_extra !== 1'b0) begin n_fail++; $display("FAIL rand[%0d]_timing: got bus=%0d lat=%0d expected bus=%b", i, t_bus, t_lat, m_bus); end
            if (m_bus) begin
                n_checks++; if (t_sel !== m_sel || t_dat !== m_dat || t_we !== we || t_adr !== {addr[31:2], 2'b00} || t_stable !== 1'b1) begin n_fail++; $display("FAIL rand[%0d]_bus: got sel=%b dat=%h adr=%h expected %b/%h/%h", i, t_sel, t_dat, t_adr, m_sel, m_dat, {addr[31:2], 2'b00}); end
            end
        end
    endtask

    task automatic test_no_timeout();
        logic [31:0] addrs [2] = '{32'h106, 32'h103};
        logic [31:0] rds   [2] = '{32'hDEADBEEF, 32'h80011234};
        logic [31:0] exps  [2] = '{32'hDEADBEEF, 32'hFFFF8001};
        logic [3:0]  sels  [2] = '{4'b1111, 4'b1100};
        logic [31:0] adrs  [2] = '{32'h104, 32'h100};
        for (int i = 0; i < 2; i++) begin
            req_we = 1'b0; req_unsigned = 1'b0; req_size = (i == 0) ? 2'd2 : 2'd1;
            req_addr = addrs[i]; dwb_dat_i = rds[i]; req_valid1 = 1'b1;
            @(posedge clk); #1;
            req_valid1 = 1'b0;
            n_checks++; if (dwb_cyc_o1 !== 1'b1 || dwb_sel_o1 !== sels[i] || dwb_adr_o1 !== adrs[i]) begin n_fail++; $display("FAIL align[%0d]_bus: got cyc=%b sel=%b adr=%h expected 1/%b/%h", i, dwb_cyc_o1, dwb_sel_o1, dwb_adr_o1, sels[i], adrs[i]); end
            repeat (i == 0 ? 100 : 2) @(posedge clk);
            #1;
            n_checks++; if ({dwb_cyc_o1, dwb_stb_o1, rsp_valid1} !== 3'b110) begin n_fail++; $display("FAIL nowd[%0d]_hold: got %b expected 110", i, {dwb_cyc_o1, dwb_stb_o1, rsp_valid1}); end
            dwb_ack_i = 1'b1;
            @(posedge clk); #1;
            dwb_ack_i = 1'b0;
            n_checks++; if (rsp_valid1 !== 1'b1 || rsp_rdata1 !== exps[i] || rsp_err1 !== 1'b0 || dwb_cyc_o1 !== 1'b0) begin n_fail++; $display("FAIL nowd[%0d]_rsp: got v=%b rdata=%h err=%b expected 1/%h/0", i, rsp_valid1, rsp_rdata1, rsp_err1, exps[i]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misalign();
        test_timeout();
        test_ack_err();
        test_async_reset();
        test_back_to_back();
        test_random();
        test_no_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
